// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: md_func encodings, cycle defaults, sequencer states.
// No logic of its own. It is used by md_sequencer, md_div_core and the decode controller.
// Backpressure: not applicable.
package md_pkg;

    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MTHI = 3'd1;
    localparam logic [2:0] MD_MTLO = 3'd2;
    localparam logic [2:0] MD_MULT = 3'd3;
    localparam logic [2:0] MD_DIV  = 3'd4;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_t;

    // Two's-complement magnitude when neg is set. 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring divider on magnitudes: produces one quotient bit per step, with a combinational sign fix on the outputs.
// Latency: one load cycle, then 32 steps. Outputs are valid once the last step has been taken.
// Backpressure: none. The sequencer asserts load and step, and the core never stalls.
module md_div_core
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        sign,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        zero_q;
    logic [32:0] trial;
    logic [32:0] diff;

    // The partial remainder stays below the divisor, so the shifted trial value fits in 33 bits.
    // diff[32] acts as the borrow.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
        end else if (load) begin
            quo_q     <= mag32(dividend, sign & dividend[31]);
            rem_q     <= '0;
            dvs_q     <= mag32(divisor, sign & divisor[31]);
            neg_quo_q <= sign & (dividend[31] ^ divisor[31]);
            neg_rem_q <= sign & dividend[31];
            zero_q    <= (divisor == 32'd0);
        end else if (step) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = mag32(quo_q, neg_quo_q);
    assign remainder = mag32(rem_q, neg_rem_q);
    assign div_zero  = zero_q;

endmodule

// File: rtl/md_sequencer.sv
// HI/LO sequencer: handles mthi/mtlo immediately, a latched multiply, and an iterative divide.
// Latency: mthi/mtlo write on the accepting edge. Mult is busy MUL_CYCLES cycles and div is busy DIV_CYCLES cycles.
// Backpressure: while busy, new starts are ignored and md_stall holds the pipeline for mfhi/mflo or a new op.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    input  logic        rd_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        md_stall
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    // DIV state covers every busy cycle except the single FIX cycle.
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      prod_q, prod_d;
    logic [63:0]      ext_a;
    logic [63:0]      ext_b;
    logic             accept;
    logic             div_load;
    logic             div_step;
    logic [31:0]      div_quo;
    logic [31:0]      div_rem;
    logic             div_zero;

    assign accept = start & ~flush & ~busy & (md_func != MD_NONE);
    assign ext_a  = md_sign ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
    assign ext_b  = md_sign ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_d   = prod_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (md_func)
                        MD_MTHI: hi_d = rs_data;
                        MD_MTLO: lo_d = rs_data;
                        MD_MULT: begin
                            prod_d  = ext_a * ext_b;
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
                        MD_DIV: begin
                            div_load = 1'b1;
                            cnt_d    = DIV_LOAD;
                            state_d  = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!div_zero) begin
                    hi_d = div_rem;
                    lo_d = div_quo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
        end
    end

    md_div_core u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .sign      (md_sign),
        .dividend  (rs_data),
        .divisor   (rt_data),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div_zero  (div_zero)
    );

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = ((state_q == ST_MUL) && (cnt_q == '0)) || (state_q == ST_FIX);
    assign md_stall = busy & (rd_req | (start & (md_func != MD_NONE)));

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the stimulus queues expected HI/LO and busy length for each mult/div operation.
// A monitor pops an entry on each done pulse and checks the write on the following edge.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_func = 3'd0;
    logic        md_sign = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        md_stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   busy_len = 0;
    bit   pending = 1'b0;

    md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(33)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_func  (md_func),
        .md_sign  (md_sign),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .rd_req   (rd_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = n;
        e.hi = h;
        e.lo = l;
        e.cycles = c;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_func = f;
        md_sign = s;
        rs_data = a;
        rt_data = b;
        tick;
        start = 1'b0;
        md_func = MD_NONE;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // Monitor: pops an expectation on done, and checks HI/LO on the next falling edge (after the write).
    always @(negedge clk) begin
        if (pending) begin
            pending = 1'b0;
            check({cur.name, "_hi"}, hi, cur.hi);
            check({cur.name, "_lo"}, lo, cur.lo);
            check({cur.name, "_busy_clear"}, 32'(busy), 32'd0);
        end
        if (busy) busy_len++;
        else busy_len = 0;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding, required 0");
            end else begin
                cur = exp_q.pop_front();
                check({cur.name, "_done_cycle"}, 32'(busy_len), 32'(cur.cycles));
                pending = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        // Reset, with requests applied that must not produce a stall.
        reset = 1'b0;
        rd_req = 1'b1;
        start = 1'b1;
        md_func = MD_MULT;
        repeat (3) tick;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(md_stall), 32'd0);
        start = 1'b0;
        md_func = MD_NONE;
        rd_req = 1'b0;
        reset = 1'b1;
        tick;

        // Signed mult with an mfhi hazard, plus a second start that must be ignored.
        expect_op("mult_s", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MD_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", 32'(busy), 32'd1);
        rd_req = 1'b1;
        #1 check("stall_rd", 32'(md_stall), 32'd1);
        tick;
        start = 1'b1;
        md_func = MD_MULT;
        rs_data = 32'd7;
        rt_data = 32'd9;
        #1 check("stall_2nd_start", 32'(md_stall), 32'd1);
        tick;
        start = 1'b0;
        md_func = MD_NONE;
        for (int i = 0; i < 10 && busy; i++) begin
            check("stall_hold", 32'(md_stall), 32'd1);
            tick;
        end
        check("stall_after", 32'(md_stall), 32'd0);
        rd_req = 1'b0;
        wait_idle("mult_s");

        // An unsigned mult accepted in the first idle cycle; a signed result would differ.
        expect_op("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("multu");

        expect_op("divu", 32'd2, 32'd14, 33);
        issue(MD_DIV, 1'b0, 32'd100, 32'd7);
        wait_idle("divu");

        expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        issue(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_neg");

        expect_op("div_ovf", 32'd0, 32'h8000_0000, 33);
        issue(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");
        tick;

        // mthi/mtlo preload with zero busy cycles.
        issue(MD_MTHI, 1'b0, 32'h11, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 1'b0, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);

        // Divide by zero leaves HI/LO untouched, but done still pulses.
        expect_op("div_zero", 32'h11, 32'h22, 33);
        issue(MD_DIV, 1'b1, 32'd5, 32'd0);
        wait_idle("div_zero");
        tick;

        // Flushed starts are not accepted.
        flush = 1'b1;
        issue(MD_MULT, 1'b0, 32'd3, 32'd3);
        check("flush_mult_busy", 32'(busy), 32'd0);
        issue(MD_MTHI, 1'b0, 32'h99, 32'd0);
        check("flush_mthi_hi", hi, 32'h11);
        flush = 1'b0;

        // A flush during busy does not abort; HI/LO stay stable until the write.
        expect_op("div_flush", 32'd0, 32'd100, 33);
        issue(MD_DIV, 1'b0, 32'd1000, 32'd10);
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            check("busy_hi_stable", hi, 32'h11);
            check("busy_lo_stable", lo, 32'h22);
            tick;
        end
        wait_idle("div_flush");
        tick;

        // Reset in busy cycle 10 of a divide discards it.
        issue(MD_DIV, 1'b0, 32'd100, 32'd7);
        repeat (9) tick;
        reset = 1'b0;
        tick;
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b1;
        issue(MD_MTHI, 1'b0, 32'h33, 32'd0);
        check("post_rst_mthi", hi, 32'h33);

        repeat (40) tick;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
